mem_arbiter: RTL

- Shares the single-ported, byte-addressed, 32-bit memory between two requesters: instruction fetch (IF) and the data port (MEM stage).
- Performs load byte/half/word extraction with sign or zero extension.
- Stores are word-wide only at the memory, so byte and half stores are done as read-modify-write.
- Sits between the pipeline's fetch and load/store units and the memory's `address`/`read_write`/`data_in`/`data_out` port.

---
 rtl/mem_arbiter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, byte-addressed 32-bit memory
// between instruction fetch and the data port. It extracts and extends
// sub-word loads and turns byte/half stores into read-modify-write.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  // instruction fetch port
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  // data port
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  // memory port
  output logic [31:0] mem_address,
  output logic [31:0] mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RSP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;

  // latched request
  logic            is_if_q, is_if_d;
  logic [31:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [15:0]     sub_wdata_q, sub_wdata_d;
  logic [31:0]     wr_word_q, wr_word_d;
  logic [31:0]     last_addr_q, last_addr_d;

  // registered responses
  logic            if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]     if_rsp_data_q, if_rsp_data_d;
  logic            d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]     d_rsp_data_q, d_rsp_data_d;
  logic            d_rsp_err_q, d_rsp_err_d;

  logic            starved;
  logic            grant_d;
  logic            grant_if;
  logic            d_req_err;
  logic [31:0]     aligned_addr;
  logic [31:0]     load_ext;
  logic [3:0]      lane_en;
  logic [31:0]     lane_data;
  logic [31:0]     merged_word;

  assign starved      = (starve_q == STARVE_MAX);
  assign aligned_addr = {addr_q[31:2], 2'b00};

  // Arbitration: the data port normally wins; a starved fetch overrides it.
  assign grant_d  = (state_q == S_IDLE) && d_req_valid && !(starved && if_req_valid);
  assign grant_if = (state_q == S_IDLE) && if_req_valid && (!d_req_valid || starved);

  // Readies stay low during a reset cycle so nothing appears accepted.
  assign d_req_ready  = reset_n && grant_d;
  assign if_req_ready = reset_n && grant_if;

  // Illegal size or misalignment, decoded on the incoming request.
  assign d_req_err = (d_size == 2'b11) ||
                     ((d_size == 2'b01) && d_addr[0]) ||
                     ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));

  // Memory port: address only moves while accessing; write gated by reset.
  assign mem_address    = ((state_q == S_RD) || (state_q == S_WR)) ? aligned_addr : last_addr_q;
  assign mem_read_write = {31'd0, (state_q == S_WR) && reset_n};
  assign mem_data_in    = (state_q == S_WR) ? wr_word_q : 32'd0;

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
  assign d_rsp_err    = d_rsp_err_q;

  // Load lane selection with sign/zero extension from the read word.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = 8'd0;
    half_sel = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = mem_data_out[7:0];
      2'b01:   byte_sel = mem_data_out[15:8];
      2'b10:   byte_sel = mem_data_out[23:16];
      default: byte_sel = mem_data_out[31:24];
    endcase
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_data_out;
    endcase
  end

  // Byte enables and replicated store data for the read-modify-write merge.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = {2{sub_wdata_q}};
    if (size_q == 2'b00) begin
      lane_en   = 4'b0001 << addr_q[1:0];
      lane_data = {4{sub_wdata_q[7:0]}};
    end else if (size_q == 2'b01) begin
      lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[gi*8 +: 8] = lane_en[gi] ? lane_data[gi*8 +: 8] : mem_data_out[gi*8 +: 8];
  end

  // Next-state, request latching and response generation.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    is_if_d        = is_if_q;
    addr_d         = addr_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    sub_wdata_d    = sub_wdata_q;
    wr_word_d      = wr_word_q;
    last_addr_d    = last_addr_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    d_rsp_valid_d  = 1'b0;
    d_rsp_data_d   = d_rsp_data_q;
    d_rsp_err_d    = 1'b0;

    if (grant_if) begin
      starve_d = '0;
    end else if (grant_d && if_req_valid && !starved) begin
      starve_d = starve_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          is_if_d     = 1'b0;
          addr_d      = d_addr;
          we_d        = d_we;
          size_d      = d_size;
          uns_d       = d_unsigned;
          sub_wdata_d = d_wdata[15:0];
          if (d_req_err) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_err_d   = 1'b1;
            d_rsp_data_d  = 32'd0;
          end else if (d_we && (d_size == 2'b10)) begin
            wr_word_d = d_wdata;
            state_d   = S_WR;
          end else begin
            state_d = S_RD;
          end
        end else if (grant_if) begin
          is_if_d = 1'b1;
          addr_d  = if_addr;
          we_d    = 1'b0;
          size_d  = 2'b10;
          uns_d   = 1'b0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        last_addr_d = aligned_addr;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (is_if_q) begin
          if_rsp_valid_d = 1'b1;
          if_rsp_data_d  = mem_data_out;
          state_d        = S_IDLE;
        end else if (!we_q) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_data_d  = load_ext;
          state_d       = S_IDLE;
        end else begin
          wr_word_d = merged_word;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        last_addr_d   = aligned_addr;
        d_rsp_valid_d = 1'b1;
        d_rsp_data_d  = 32'd0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      starve_q       <= '0;
      is_if_q        <= 1'b0;
      addr_q         <= 32'd0;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      sub_wdata_q    <= 16'd0;
      wr_word_q      <= 32'd0;
      last_addr_q    <= 32'd0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= 32'd0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= 32'd0;
      d_rsp_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      is_if_q        <= is_if_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      sub_wdata_q    <= sub_wdata_d;
      wr_word_q      <= wr_word_d;
      last_addr_q    <= last_addr_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_data_q   <= d_rsp_data_d;
      d_rsp_err_q    <= d_rsp_err_d;
    end
  end

endmodule
